// File: rtl/sca_ch_enable_sequencer_pkg.sv
// sca_ch_enable_sequencer_pkg: shared constants and FSM state type for the channel enable sequencer
package sca_ch_enable_sequencer_pkg;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 2'd3;
    localparam int MIN_STAGGER = 4;
    typedef enum logic {IDLE, WAIT} seq_state_t;
endpackage

// File: rtl/sca_lowest_one_sel.sv
// sca_lowest_one_sel: one-hot of the lowest set request bit plus any-valid flag
module sca_lowest_one_sel #(
    parameter int N_CH = 22
) (
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] onehot,
    output logic            any
);
    assign onehot = req & (~req + N_CH'(1));
    assign any = |req;
endmodule

// File: rtl/sca_ch_enable_sequencer.sv
// sca_ch_enable_sequencer: register-controlled channel enable mask with staggered enables and immediate disables
module sca_ch_enable_sequencer
    import sca_ch_enable_sequencer_pkg::*;
#(
    parameter int N_CH = 22,
    parameter int STAGGER = 4
) (
    input  logic              clk,
    input  logic              resetB,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              force_off,
    output logic [N_CH-1:0]   ch_enable,
    output logic              busy
);
    localparam int CNT_W = $clog2(STAGGER);

    generate
        if (STAGGER < MIN_STAGGER || N_CH < 1 || N_CH > 24) begin : g_bad_params
            $error("sca_ch_enable_sequencer: STAGGER must be >= MIN_STAGGER and N_CH in 1..24");
        end
    endgenerate

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0]  tgt, tgt_next, pend, onehot;
    logic [23:0]      tgt_w;
    logic [4:0]       sh;
    logic             pend_any, accept, wr_ok;

    assign tgt_w = 24'(tgt);
    assign sh = {cmd_addr, 3'b000};
    assign cmd_ready = ~rsp_valid;
    assign accept = cmd_valid & ~rsp_valid;
    assign wr_ok = accept & cmd_write & (cmd_addr != STATUS_ADDR) & ~force_off;
    assign tgt_next = force_off ? '0 :
                      wr_ok ? N_CH'((tgt_w & ~(24'hFF << sh)) | (24'(cmd_wdata) << sh)) : tgt;
    assign pend = tgt & ~ch_enable;
    assign busy = (state == WAIT) | pend_any;

    sca_lowest_one_sel #(.N_CH(N_CH)) u_sel (
        .req(pend),
        .onehot(onehot),
        .any(pend_any)
    );

    // Target mask and single-entry command response register
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            tgt <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            tgt <= tgt_next;
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= cmd_write ? '0 :
                             (cmd_addr == STATUS_ADDR) ? {6'b0, force_off, busy} : 8'(tgt_w >> sh);
                rsp_err <= cmd_write & ((cmd_addr == STATUS_ADDR) | force_off);
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Stagger FSM: enable one pending channel, then hold off STAGGER cycles; disables apply at once
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state <= IDLE;
            cnt <= '0;
            ch_enable <= '0;
        end else if (force_off) begin
            state <= IDLE;
            cnt <= '0;
            ch_enable <= '0;
        end else begin
            ch_enable <= (ch_enable | ((state == IDLE) ? onehot : '0)) & tgt_next;
            if (state == IDLE && pend_any) begin
                state <= WAIT;
                cnt <= CNT_W'(STAGGER - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sca_ch_enable_sequencer.sv
// tb_sca_ch_enable_sequencer: table-driven and scoreboard bench for the channel enable sequencer
module tb_sca_ch_enable_sequencer;
    logic        clk = 1'b0;
    logic        resetB;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        force_off;
    logic [21:0] ch_enable;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int tag_cnt = 0;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         tag;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] er;
        logic       ee;
    } vec_t;
    vec_t vt[10];

    sca_ch_enable_sequencer #(.N_CH(22), .STAGGER(4)) dut (
        .clk(clk),
        .resetB(resetB),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .force_off(force_off),
        .ch_enable(ch_enable),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one command at a negedge, record its expected response, return at the negedge after accept
    task automatic cmd(input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic [7:0] er, input logic ee);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        exp_q.push_back('{rd: er, err: ee, tag: tag_cnt});
        tag_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Response scoreboard: compare each consumed response with the oldest expectation
    always begin
        @(negedge clk);
        #1;
        if (resetB && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got rdata %0h err %0b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rsp%0d_rdata", e.tag), 32'(rsp_rdata), 32'(e.rd));
                chk($sformatf("rsp%0d_err", e.tag), 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic low_clean;
        int n;
        vt[0] = '{w: 1'b0, a: 2'd0, d: 8'h00, er: 8'h00, ee: 1'b0};
        vt[1] = '{w: 1'b0, a: 2'd1, d: 8'h00, er: 8'h00, ee: 1'b0};
        vt[2] = '{w: 1'b0, a: 2'd2, d: 8'h00, er: 8'h00, ee: 1'b0};
        vt[3] = '{w: 1'b0, a: 2'd3, d: 8'h00, er: 8'h00, ee: 1'b0};
        vt[4] = '{w: 1'b1, a: 2'd2, d: 8'hFF, er: 8'h00, ee: 1'b0};
        vt[5] = '{w: 1'b0, a: 2'd2, d: 8'h00, er: 8'h3F, ee: 1'b0};
        vt[6] = '{w: 1'b1, a: 2'd3, d: 8'h55, er: 8'h00, ee: 1'b1};
        vt[7] = '{w: 1'b0, a: 2'd3, d: 8'h00, er: 8'h01, ee: 1'b0};
        vt[8] = '{w: 1'b0, a: 2'd0, d: 8'h00, er: 8'h00, ee: 1'b0};
        vt[9] = '{w: 1'b0, a: 2'd1, d: 8'h00, er: 8'h00, ee: 1'b0};

        resetB = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = 2'd0;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        force_off = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ch_enable", 32'(ch_enable), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        resetB = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) cmd(vt[i].w, vt[i].a, vt[i].d, vt[i].er, vt[i].ee);

        low_clean = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            if (ch_enable[15:0] != 16'h0) low_clean = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("hi_byte_done", 32'(busy), 32'd0);
        chk("hi_byte_low_bits_never_set", 32'(low_clean), 32'd1);
        chk("hi_byte_ch_enable", 32'(ch_enable), 32'h3F0000);

        cmd(1'b1, 2'd2, 8'h00, 8'h00, 1'b0);
        chk("clear_latency_1", 32'(ch_enable), 32'd0);

        cmd(1'b1, 2'd0, 8'h07, 8'h00, 1'b0);
        chk("stag_t1_en", 32'(ch_enable), 32'd0);
        chk("stag_t1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("stag_k%0d_en", k), 32'(ch_enable), (k < 5) ? 32'h1 : (k < 9) ? 32'h3 : 32'h7);
            chk($sformatf("stag_k%0d_busy", k), 32'(busy), (k < 12) ? 32'd1 : 32'd0);
        end

        cmd(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        chk("clear_all", 32'(ch_enable), 32'd0);
        cmd(1'b1, 2'd0, 8'h07, 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        chk("drop_pre_en", 32'(ch_enable), 32'h3);
        cmd(1'b1, 2'd0, 8'h01, 8'h00, 1'b0);
        chk("drop_next_cycle", 32'(ch_enable), 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("drop_hold%0d", k), 32'(ch_enable), 32'h1);
        end
        chk("drop_busy_done", 32'(busy), 32'd0);

        cmd(1'b1, 2'd0, 8'hFF, 8'h00, 1'b0);
        cmd(1'b1, 2'd1, 8'hFF, 8'h00, 1'b0);
        cmd(1'b1, 2'd2, 8'hFF, 8'h00, 1'b0);
        repeat (6) @(negedge clk);
        chk("fo_pre_busy", 32'(busy), 32'd1);
        force_off = 1'b1;
        @(negedge clk);
        chk("fo_ch_enable", 32'(ch_enable), 32'd0);
        chk("fo_busy", 32'(busy), 32'd0);
        cmd(1'b1, 2'd0, 8'hFF, 8'h00, 1'b1);
        cmd(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        cmd(1'b0, 2'd2, 8'h00, 8'h00, 1'b0);
        cmd(1'b0, 2'd3, 8'h00, 8'h02, 1'b0);
        force_off = 1'b0;
        repeat (3) @(negedge clk);
        chk("fo_release_en", 32'(ch_enable), 32'd0);

        cmd(1'b1, 2'd0, 8'h5A, 8'h00, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd(1'b0, 2'd0, 8'h00, 8'h5A, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d_rdata", k), 32'(rsp_rdata), 32'h5A);
            chk($sformatf("hold%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        cmd(1'b1, 2'd3, 8'hAA, 8'h00, 1'b1);

        cmd(1'b1, 2'd0, 8'hFF, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        resetB = 1'b0;
        #1;
        chk("async_rst_ch_enable", 32'(ch_enable), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("async_rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("async_rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        resetB = 1'b1;
        @(negedge clk);
        cmd(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sca_ch_enable_sequencer.md
Name: sca_ch_enable_sequencer

Overview:
- Controller that owns the per-channel enable vector feeding the triplicated channel clock-gating/reset block (one sequencer instance per TMR domain).
- Accepts byte-wide register read/write commands from the SCA command decoder and holds a target enable mask.
- Disables take effect immediately.
- Enables are applied one channel at a time, with a programmable stagger, so that clock-gate release and channel reset deassertion never coincide across channels.

Parameters:
- N_CH, 22, number of channels (1..24).
- STAGGER, 4, cycles between successive channel enables; minimum 4, because the gating FSM needs 3 cycles to release reset.

Ports:
- clk  in  1  global clock
- resetB  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  2  0..2 = target-mask byte 0..2; 3 = status
- cmd_wdata  in  8  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_rdata  out  8  read data (0 for writes)
- rsp_err  out  1  command error flag
- force_off  in  1  synchronous emergency disable-all (level)
- ch_enable  out  N_CH  per-channel enable to the clock-gating block
- busy  out  1  enable sequencing in progress

Behaviour:
- Reset (resetB low, async): tgt=0, ch_enable=0, FSM=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=1, busy=0.
- Command handshake: cmd_ready = ~rsp_valid.
  - On accept, rsp_valid=1 on the next cycle, with rsp_rdata/rsp_err valid.
  - Response is held until rsp_ready. rsp_ready in the same cycle as a new accept is impossible, because cmd_ready=0 while rsp_valid=1.
- Write addr k (0..2): tgt[8k+7:8k] <= cmd_wdata. Bits at index >= N_CH are discarded. rsp_err=0.
- Write addr 3: rsp_err=1, no state change.
- Read addr k: rsp_rdata = tgt byte k, with bits >= N_CH reading 0.
- Read addr 3: rsp_rdata = {6'b0, force_off, busy}.
- force_off=1: tgt and ch_enable cleared next cycle, FSM to IDLE, counter=0. Writes accepted while force_off=1 respond rsp_err=1 and do not modify tgt. Reads respond normally.
- FSM:
  - IDLE: if pend = tgt & ~ch_enable is nonzero, set bit i = lowest set index of pend, load counter=STAGGER-1, go WAIT.
  - WAIT: decrement counter; at 0 go IDLE.
  - IDLE re-evaluates pend in the cycle it is entered, so the enable spacing is exactly STAGGER cycles.
- Update rule: ch_enable_next = (ch_enable | onehot_set) & tgt_next.
  - A disable always wins, including when it coincides with the enable of the same bit.
  - Clearing a bit during WAIT drops it next cycle; the counter continues.
- busy = (FSM==WAIT) | (|pend), combinational from registers.
- Latency:
  - A write that only clears bits: ch_enable changes 1 cycle after accept.
  - A write setting bit(s) from IDLE: first enable 2 cycles after accept (tgt registers, then FSM sets).

Decomposition:
- Shared package: STATUS_ADDR=2'd3, ADDR_W=2, DATA_W=8, the FSM state enum {IDLE, WAIT}, and MIN_STAGGER=4 (elaboration check STAGGER>=MIN_STAGGER).
- Natural sub-module: sca_lowest_one_sel (parameterised N_CH priority encoder returning one-hot lowest set bit plus any-valid).

Test Plan:
- Reset, then read addr 0..3 -> rdata 0x00 each, rsp_err=0, ch_enable=0, busy=0.
- Write addr0=0x07 at cycle T -> ch_enable=0x1 at T+2, 0x3 at T+6, 0x7 at T+10 (STAGGER=4); busy deasserts at T+13.
- Write addr2=0xFF with N_CH=22 -> read addr2 returns 0x3F; only bits 16..21 are ever enabled.
- With ch_enable=0x3 and bit2 pending, write addr0=0x01 -> bit1 drops next cycle; bit2 is never enabled.
- Assert force_off mid-sequence with tgt=0x3FFFFF -> ch_enable=0 and tgt=0 next cycle; a write during force_off gives rsp_err=1 with tgt still 0; status read gives 0x02.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid/rdata stable and cmd_ready=0 throughout; write addr3 -> rsp_err=1. Assert resetB low during WAIT -> all outputs return to reset values asynchronously.
